// File: rtl/inst_queue_nw_if.sv
// inst_queue_nw_if: handshake bundle between IF (producer/consumer side) and
// the N-wide instruction queue.
//   flush       : discard queue contents (driven by the master)
//   in_valid    : per-lane enqueue valid, sparse patterns allowed
//   in_data     : per-lane payload, lane k = in_data[k]
//   in_ready    : whole in bundle accepted this cycle (combinational)
//   out_valid   : thermometer, bit k = (count > k)
//   out_data    : lane k = k-th oldest entry, zero when invalid
//   deq_cnt     : entries the consumer takes this cycle
//   count       : registered occupancy
//   almost_full : registered, free slots < AF_THRESH
//   err_deq     : sticky, consumer took more than count
interface inst_queue_nw_if #(
  parameter int ENQ_W  = 2,
  parameter int DEQ_W  = 2,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 64
);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int DCNT_W = $clog2(DEQ_W + 1);

  logic                               flush;
  logic [ENQ_W-1:0]                   in_valid;
  logic [ENQ_W-1:0][DATA_W-1:0]       in_data;
  logic                               in_ready;
  logic [DEQ_W-1:0]                   out_valid;
  logic [DEQ_W-1:0][DATA_W-1:0]       out_data;
  logic [DCNT_W-1:0]                  deq_cnt;
  logic [CNT_W-1:0]                   count;
  logic                               almost_full;
  logic                               err_deq;

  modport master (
    output flush, in_valid, in_data, deq_cnt,
    input  in_ready, out_valid, out_data, count, almost_full, err_deq
  );
  modport slave (
    input  flush, in_valid, in_data, deq_cnt,
    output in_ready, out_valid, out_data, count, almost_full, err_deq
  );
endinterface

// File: rtl/inst_queue_nw.sv
// inst_queue_nw: parametrised N-wide instruction queue between IF and
// PreDecode. Up to ENQ_W sparse lanes are compacted and enqueued per cycle
// (all-or-nothing); up to DEQ_W oldest entries are presented with zero
// latency and the consumer reports how many it took.
//   clk, rst_n : clock, asynchronous active-low reset
//   q          : inst_queue_nw_if.slave bundle (see interface header)

// Per-dequeue-lane read address / valid generation.
module inst_queue_nw_rd_lane #(
  parameter int DEPTH = 16,
  parameter int LANE  = 0,
  parameter int PTR_W = 4,
  parameter int CNT_W = 5
) (
  input  logic [PTR_W-1:0] head,
  input  logic [CNT_W-1:0] count,
  output logic [PTR_W-1:0] slot,
  output logic             vld
);
  localparam int SUM_W = PTR_W + 1;
  logic [SUM_W-1:0] sum;

  // head < DEPTH and LANE < DEPTH, so one conditional subtract wraps.
  assign sum  = {1'b0, head} + SUM_W'(LANE);
  assign slot = (sum >= SUM_W'(DEPTH)) ? PTR_W'(sum - SUM_W'(DEPTH)) : sum[PTR_W-1:0];
  assign vld  = (count > CNT_W'(LANE));
endmodule

module inst_queue_nw #(
  parameter int ENQ_W     = 2,
  parameter int DEQ_W     = 2,
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 64,
  parameter int AF_THRESH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  inst_queue_nw_if.slave  q
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic              af, err;

  int                        n_in, eff_deq, count_nxt;
  logic                      in_ready, push, deq_err;
  logic [ENQ_W-1:0][PTR_W-1:0] wr_slot;

  // Pointer add modulo DEPTH; n never exceeds DEPTH so one subtract suffices.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  always_comb begin
    n_in    = 0;
    wr_slot = '0;
    // Compaction: each valid lane's rank among lower valid lanes picks its slot.
    for (int k = 0; k < ENQ_W; k++) begin
      wr_slot[k] = wrap_add(tail, n_in);
      if (q.in_valid[k]) n_in = n_in + 1;
    end
    eff_deq = int'(q.deq_cnt);
    if (eff_deq > int'(count)) eff_deq = int'(count);
    if (eff_deq > DEQ_W)       eff_deq = DEQ_W;
    // Ready credits this cycle's dequeue, so a full queue can swap entries.
    in_ready  = (n_in <= DEPTH - int'(count) + eff_deq);
    push      = in_ready && (n_in > 0) && !q.flush;
    deq_err   = !q.flush && (int'(q.deq_cnt) > int'(count));
    count_nxt = q.flush ? 0 : int'(count) - eff_deq + (in_ready ? n_in : 0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      af    <= (DEPTH < AF_THRESH);
      err   <= 1'b0;
    end else begin
      if (q.flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        head <= wrap_add(head, eff_deq);
        if (in_ready) tail <= wrap_add(tail, n_in);
      end
      count <= CNT_W'(count_nxt);
      af    <= ((DEPTH - count_nxt) < AF_THRESH);
      err   <= err | deq_err;
    end
  end

  // Payload storage carries no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < ENQ_W; k++)
        if (q.in_valid[k]) mem[wr_slot[k]] <= q.in_data[k];
    end
  end

  logic [DEQ_W-1:0]              rd_vld;
  logic [DEQ_W-1:0][PTR_W-1:0]   rd_slot;
  logic [DEQ_W-1:0][DATA_W-1:0]  rd_data;

  for (genvar k = 0; k < DEQ_W; k++) begin : g_rd
    inst_queue_nw_rd_lane #(
      .DEPTH (DEPTH),
      .LANE  (k),
      .PTR_W (PTR_W),
      .CNT_W (CNT_W)
    ) u_lane (
      .head  (head),
      .count (count),
      .slot  (rd_slot[k]),
      .vld   (rd_vld[k])
    );
    assign rd_data[k] = rd_vld[k] ? mem[rd_slot[k]] : '0;
  end

  assign q.in_ready    = in_ready;
  assign q.out_valid   = rd_vld;
  assign q.out_data    = rd_data;
  assign q.count       = count;
  assign q.almost_full = af;
  assign q.err_deq     = err;
endmodule

// File: tb/tb_inst_queue_nw.sv
module tb_inst_queue_nw;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  inst_queue_nw_if #(.ENQ_W(2), .DEQ_W(2), .DEPTH(16), .DATA_W(64)) b16 ();
  inst_queue_nw_if #(.ENQ_W(2), .DEQ_W(2), .DEPTH(5),  .DATA_W(64)) b5 ();

  inst_queue_nw #(.ENQ_W(2), .DEQ_W(2), .DEPTH(16), .DATA_W(64), .AF_THRESH(4))
    dut16 (.clk(clk), .rst_n(rst_n), .q(b16));
  inst_queue_nw #(.ENQ_W(2), .DEQ_W(2), .DEPTH(5), .DATA_W(64), .AF_THRESH(4))
    dut5 (.clk(clk), .rst_n(rst_n), .q(b5));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        flush;
    logic [1:0]  iv;
    logic [63:0] d0, d1;
    logic [1:0]  deq;
    logic        ready;
    int          cnt;
    logic [1:0]  ov;
    logic [63:0] l0, l1;
    logic        af, err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic fl, input logic [1:0] iv, input logic [63:0] d0, d1,
                     input logic [1:0] deq, input logic rdy, input int cnt,
                     input logic [1:0] ov, input logic [63:0] l0, l1,
                     input logic af, err);
    vec_t v;
    v.flush = fl; v.iv = iv; v.d0 = d0; v.d1 = d1; v.deq = deq; v.ready = rdy;
    v.cnt = cnt; v.ov = ov; v.l0 = l0; v.l1 = l1; v.af = af; v.err = err;
    vq.push_back(v);
  endtask

  task automatic apply16(input vec_t v, input int idx);
    @(negedge clk);
    b16.flush = v.flush; b16.in_valid = v.iv; b16.in_data[0] = v.d0;
    b16.in_data[1] = v.d1; b16.deq_cnt = v.deq;
    #1;
    chk($sformatf("v%0d in_ready", idx), 64'(b16.in_ready), 64'(v.ready));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d count", idx), 64'(b16.count), 64'(v.cnt));
    chk($sformatf("v%0d out_valid", idx), 64'(b16.out_valid), 64'(v.ov));
    chk($sformatf("v%0d lane0", idx), b16.out_data[0], v.l0);
    chk($sformatf("v%0d lane1", idx), b16.out_data[1], v.l1);
    chk($sformatf("v%0d almost_full", idx), 64'(b16.almost_full), 64'(v.af));
    chk($sformatf("v%0d err_deq", idx), 64'(b16.err_deq), 64'(v.err));
  endtask

  task automatic idle16();
    b16.flush = 0; b16.in_valid = 0; b16.in_data = '0; b16.deq_cnt = 0;
  endtask

  task automatic idle5();
    b5.flush = 0; b5.in_valid = 0; b5.in_data = '0; b5.deq_cnt = 0;
  endtask

  initial begin
    idle16();
    idle5();
    #3;
    chk("rst count", 64'(b16.count), 0);
    chk("rst out_valid", 64'(b16.out_valid), 0);
    chk("rst out_data", 64'(b16.out_data[0] | b16.out_data[1]), 0);
    chk("rst almost_full", 64'(b16.almost_full), 0);
    chk("rst err_deq", 64'(b16.err_deq), 0);
    chk("rst in_ready", 64'(b16.in_ready), 1);
    chk("rst5 count", 64'(b5.count), 0);
    chk("rst5 almost_full", 64'(b5.almost_full), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill: two per cycle, almost_full once free < 4.
    for (int i = 0; i < 8; i++)
      add(0, 2'b11, 64'(2*i+1), 64'(2*i+2), 0, 1, 2*i+2, 2'b11, 1, 2,
          (16 - (2*i+2)) < 4, 0);
    add(0, 2'b11, 201, 202, 0, 0, 16, 2'b11, 1, 2, 1, 0);   // full, held
    add(0, 2'b11, 101, 102, 2, 1, 16, 2'b11, 3, 4, 1, 0);   // full swap
    add(0, 2'b11, 103, 104, 1, 0, 15, 2'b11, 4, 5, 1, 0);   // not enough room
    add(0, 2'b00, 0, 0, 2, 1, 13, 2'b11, 6, 7, 1, 0);
    add(0, 2'b00, 0, 0, 2, 1, 11, 2'b11, 8, 9, 0, 0);
    add(0, 2'b00, 0, 0, 2, 1, 9,  2'b11, 10, 11, 0, 0);
    add(0, 2'b00, 0, 0, 2, 1, 7,  2'b11, 12, 13, 0, 0);
    add(1, 2'b11, 301, 302, 2, 1, 0, 2'b00, 0, 0, 0, 0);    // flush wins
    add(1, 2'b00, 0, 0, 2, 1, 0, 2'b00, 0, 0, 0, 0);        // flush masks err
    add(0, 2'b10, 64'h55, 64'hA, 0, 1, 1, 2'b01, 64'hA, 0, 0, 0); // compaction
    add(0, 2'b01, 64'hB, 64'h66, 0, 1, 2, 2'b11, 64'hA, 64'hB, 0, 0);
    add(0, 2'b00, 0, 0, 1, 1, 1, 2'b01, 64'hB, 0, 0, 0);
    add(0, 2'b00, 0, 0, 2, 1, 0, 2'b00, 0, 0, 0, 1);        // over-dequeue
    add(0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 1);        // sticky
    add(0, 2'b11, 64'hC, 64'hD, 3, 1, 2, 2'b11, 64'hC, 64'hD, 0, 1);

    for (int i = 0; i < vq.size(); i++) apply16(vq[i], i);

    // Asynchronous reset mid-cycle, checked before the next clock edge.
    @(negedge clk);
    idle16();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst count", 64'(b16.count), 0);
    chk("arst out_valid", 64'(b16.out_valid), 0);
    chk("arst out_data", 64'(b16.out_data[0] | b16.out_data[1]), 0);
    chk("arst err_deq", 64'(b16.err_deq), 0);
    chk("arst almost_full", 64'(b16.almost_full), 0);
    chk("arst in_ready", 64'(b16.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    vq.delete();
    add(0, 2'b11, 64'hE, 64'hF, 0, 1, 2, 2'b11, 64'hE, 64'hF, 0, 0);
    apply16(vq[0], 100);

    // Random wrap test on DEPTH=5 against a queue model.
    begin
      logic [63:0] m[$];
      int          got[$];
      int          next_val = 1, gen_next = 1;
      logic        have = 0;
      logic [1:0]  piv = 0;
      logic [63:0] pd0 = 0, pd1 = 0;
      int          deq, n, cyc = 0;
      logic        exp_rdy;
      while (got.size() < 20 && cyc < 400) begin
        cyc++;
        @(negedge clk);
        if (!have && next_val <= 20) begin
          int t;
          piv = 2'($urandom_range(0, 3));
          t = next_val;
          pd0 = 0; pd1 = 0;
          if (piv[0]) begin if (t <= 20) begin pd0 = 64'(t); t++; end else piv[0] = 0; end
          if (piv[1]) begin if (t <= 20) begin pd1 = 64'(t); t++; end else piv[1] = 0; end
          gen_next = t;
          have = (piv != 0);
        end
        deq = $urandom_range(0, 2);
        if (deq > m.size()) deq = m.size();
        b5.in_valid = have ? piv : 2'b00;
        b5.in_data[0] = pd0; b5.in_data[1] = pd1;
        b5.deq_cnt = 2'(deq);
        n = int'(b5.in_valid[0]) + int'(b5.in_valid[1]);
        exp_rdy = (n <= 5 - m.size() + deq);
        #1;
        chk("w5 count", 64'(b5.count), 64'(m.size()));
        chk("w5 out_valid", 64'(b5.out_valid),
            64'(m.size() >= 2 ? 3 : m.size()));
        chk("w5 lane0", b5.out_data[0], m.size() > 0 ? m[0] : 64'd0);
        chk("w5 lane1", b5.out_data[1], m.size() > 1 ? m[1] : 64'd0);
        chk("w5 almost_full", 64'(b5.almost_full), 64'((5 - m.size()) < 4));
        chk("w5 err_deq", 64'(b5.err_deq), 0);
        chk("w5 in_ready", 64'(b5.in_ready), 64'(exp_rdy));
        @(posedge clk);
        for (int k = 0; k < deq; k++) got.push_back(int'(m.pop_front()));
        if (exp_rdy && n > 0) begin
          if (b5.in_valid[0]) m.push_back(pd0);
          if (b5.in_valid[1]) m.push_back(pd1);
          next_val = gen_next;
          have = 0;
        end
      end
      idle5();
      chk("w5 delivered", 64'(got.size()), 20);
      for (int i = 0; i < got.size() && i < 20; i++)
        chk($sformatf("w5 order%0d", i), 64'(got[i]), 64'(i + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
